shape_prog_scheduler: RTL
=========================

// Module: shape_prog_scheduler
// PURPOSE
//  Sits between uart_buffer and the shape register bank. Queues decoded program packets
//  (shape_addr/reg_addr/data) and replays them as single-cycle bank writes, only while the
//  renderer reports vertical blank, so shape registers never change mid-frame.
//  Also reports queue occupancy, busy and sticky overflow to the status/debug logic.
// PARAMETERS
//  SHAPE_ADDR_W  11   shape index width (matches uart_buffer shape_addr)
//  REG_ADDR_W    12   register index width within a shape
//  DATA_W        12   register data width
//  FIFO_DEPTH    16   queued packets; power of two, >= 2
// PORTS
//  clk              in   1            system clock; all logic on posedge
//  rst              in   1            synchronous, active-high reset
//  prog_valid       in   1            1-cycle strobe: new packet (uart_buffer program_out)
//  prog_shape_addr  in   SHAPE_ADDR_W packet shape index, valid with prog_valid
//  prog_reg_addr    in   REG_ADDR_W   packet register index, valid with prog_valid
//  prog_data        in   DATA_W       packet data, valid with prog_valid
//  vblank           in   1            1 = renderer not reading shape bank; writes allowed
//  wr_en            out  1            bank write strobe, one cycle per packet
//  wr_shape_addr    out  SHAPE_ADDR_W write shape index, valid with wr_en
//  wr_reg_addr      out  REG_ADDR_W   write register index, valid with wr_en
//  wr_data          out  DATA_W       write data, valid with wr_en
//  fifo_count       out  $clog2(FIFO_DEPTH)+1  packets currently queued
//  busy             out  1            1 when fifo_count != 0 or wr_en high
//  overflow         out  1            sticky: a packet was dropped because queue was full
// BEHAVIOUR
//  Reset (clk edge with rst=1): wr_en=0, wr_* = 0, fifo_count=0, busy=0, overflow=0,
//   state=S_IDLE, FIFO pointers=0. Reset dominates any push/pop in the same cycle; a
//   packet strobed during reset is discarded; a write in progress is abandoned.
//  Push: on edge with prog_valid=1, packet is enqueued if count<FIFO_DEPTH, or if
//   count==FIFO_DEPTH and a pop occurs on the same edge (count unchanged). Otherwise the
//   packet is dropped and overflow set to 1 (held until rst). FIFO order strictly preserved.
//  Pop: on edge where vblank=1 and count>0, head is popped and registered onto wr_*;
//   wr_en=1 for exactly the following cycle. At most one pop per cycle, so back-to-back
//   pops give continuous wr_en. Latency: prog_valid at edge N with empty queue and vblank=1
//   -> packet enters queue at N, popped at N+1, wr_en high in cycle after N+1 (no bypass).
//  vblank sampled low at an edge: no pop at that edge; wr_en=0 in the next cycle. Renderer
//   must drop vblank one cycle before its first shape read. A write already registered
//   completes (its wr_en cycle is not cancelled).
//  wr_* hold last value when wr_en=0 (not required to return to 0).
//  FSM (2-bit): S_IDLE  count=0                -> S_HOLD on push if vblank=0, S_DRAIN if 1
//               S_HOLD  count>0, vblank=0      -> S_DRAIN when vblank=1
//               S_DRAIN popping each cycle     -> S_HOLD on vblank=0 with count>0 after edge;
//                                                 S_IDLE when queue empties
//   Illegal state -> S_IDLE. fifo_count always equals pushes minus pops since reset, range
//   0..FIFO_DEPTH; write/read pointers wrap modulo FIFO_DEPTH.
//  busy = (count!=0) | wr_en, combinational from registers.
// STRUCTURE
//  Shared package/header: SHAPE_ADDR_W/REG_ADDR_W/DATA_W defaults (also used by
//   uart_buffer and shape bank), packet field order {data,reg_addr,shape_addr}, FSM
//   state encodings S_IDLE/S_HOLD/S_DRAIN.
//  One sub-module: prog_fifo - synchronous single-clock FIFO, width
//   SHAPE_ADDR_W+REG_ADDR_W+DATA_W, depth FIFO_DEPTH, push/pop/full/empty/count,
//   simultaneous push+pop when full allowed. Top holds FSM, pop gating, output regs, overflow.
// TESTING
//  1 Reset then vblank=1, push {shape=3,reg=5,data=12'hABC} -> wr_en 1 cycle, 2 edges later,
//    wr_*=3/5/ABC; fifo_count back to 0; busy 0 after wr_en cycle.
//  2 vblank=0, push 5 packets (data 1..5) -> no wr_en, fifo_count=5, busy=1; raise vblank ->
//    5 consecutive wr_en cycles, data 1,2,3,4,5 in order.
//  3 vblank=0, push 17 packets (depth 16) -> fifo_count=16, overflow=1; drain yields first
//    16 in order; 17th absent; overflow stays 1 until rst.
//  4 Queue 8, vblank=1 for 3 edges then 0 -> exactly 3 writes (data 1..3), count=5, no wr_en
//    while low; raise again -> remaining 4..8 follow.
//  5 Queue full (16), vblank=1, push on same edge as pop -> accepted, overflow stays 0,
//    count stays 16; total 17 writes in order.
//  6 rst mid-drain with 6 queued -> next cycle wr_en=0, count=0, overflow=0, state S_IDLE;
//    fresh push afterward writes normally.

Source files
------------

// File: rtl/shape_prog_scheduler_pkg.sv
// Shared widths, packet layout and scheduler state encodings.
// Used by uart_buffer, the shape bank and the program scheduler.
package shape_prog_scheduler_pkg;

  localparam int DEF_SHAPE_ADDR_W = 11;
  localparam int DEF_REG_ADDR_W   = 12;
  localparam int DEF_DATA_W       = 12;
  localparam int DEF_FIFO_DEPTH   = 16;

  // Packets are packed as {data, reg_addr, shape_addr}, shape_addr in the LSBs.
  function automatic int pkt_w(input int sw, input int rw, input int dw);
    return sw + rw + dw;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/shape_prog_scheduler_prog_fifo.sv
// Single-clock packet FIFO with occupancy count.
// Push while full is legal only together with a pop.
module prog_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/shape_prog_scheduler.sv
// Queues shape program packets and replays them as bank writes
// only while the renderer is in vertical blank.
module shape_prog_scheduler
  import shape_prog_scheduler_pkg::*;
#(
  parameter int SHAPE_ADDR_W = DEF_SHAPE_ADDR_W,
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_valid,
  input  logic [SHAPE_ADDR_W-1:0]       prog_shape_addr,
  input  logic [REG_ADDR_W-1:0]         prog_reg_addr,
  input  logic [DATA_W-1:0]             prog_data,
  input  logic                          vblank,
  output logic                          wr_en,
  output logic [SHAPE_ADDR_W-1:0]       wr_shape_addr,
  output logic [REG_ADDR_W-1:0]         wr_reg_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int PW = pkt_w(SHAPE_ADDR_W, REG_ADDR_W, DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [PW-1:0] head;
  logic [CW-1:0] cnt_nxt;
  state_t        state;
  state_t        nxt;

  // A full queue still accepts a packet when the head leaves on the same edge.
  assign pop  = vblank & ~empty;
  assign push = prog_valid & (~full | pop);

  prog_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({prog_data, prog_reg_addr, prog_shape_addr}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en         <= 1'b0;
      wr_shape_addr <= '0;
      wr_reg_addr   <= '0;
      wr_data       <= '0;
      overflow      <= 1'b0;
    end else begin
      wr_en <= pop;
      if (pop) {wr_data, wr_reg_addr, wr_shape_addr} <= head;
      if (prog_valid & ~push) overflow <= 1'b1;
    end
  end

  assign cnt_nxt = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (push) nxt = vblank ? S_DRAIN : S_HOLD;
      end
      S_HOLD: begin
        if (vblank) nxt = (cnt_nxt == '0) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_nxt == '0) nxt = S_IDLE;
        else if (!vblank)  nxt = S_HOLD;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign busy = (fifo_count != '0) | wr_en;

endmodule
